au_reduce16: RTL and testbench
==============================

# au_reduce16

Sequential reduction stage downstream of the 16-bit abs/max/min arithmetic unit. It accepts a block of `len` signed 16-bit samples over a valid/ready stream and applies the selected operation pairwise to a running accumulator. It emits one result word, plus the index of the winning sample, through an output handshake. It is the team's first clocked AU stage and feeds the result register file.

## Interface
Parameters:
- `W`, 16: sample/result width, two's complement.
- `LW`, 8: width of `len` and `out_idx`.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a block; honoured only in IDLE.
- `op`  in  2  operation code: 00 max(|x|), 01 max(x), 10/11 min(x). Latched on `start`.
- `len`  in  LW  sample count. 0 encodes 2^LW. Latched on `start`.
- `in_valid`  in  1  sample valid.
- `in_ready`  out  1  sample accepted when `in_valid & in_ready`.
- `in_data`  in  W  sample.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed when `out_valid & out_ready`.
- `out_data`  out  W  reduced value.
- `out_idx`  out  LW  0-based index of the winning sample.
- `busy`  out  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`. Latch `op` and `len`, clear `cnt` and `acc`.
  - RUN → DONE on the accepted sample with `cnt == len-1` (mod 2^LW).
  - DONE → IDLE on the output handshake.
- `in_ready = (state == RUN)`. It is a combinational function of state only.
- Sample transform: for `op` 00, `v = |x|`, with `|-32768|` saturating to 0x7FFF. For all other codes, `v = x`.
- Update rule on each accepted sample:
  - First sample (`cnt == 0`): `acc = v`, `idx = 0`.
  - Later samples: replace `acc` only if `v` is strictly better (greater for 00/01, less for 1x). On a replace, `idx = cnt`.
  - Ties keep the earlier index.
- Comparisons are signed W-bit. No widening is required, because `|x|` is saturated before the compare.
- `cnt` increments on each accepted sample and wraps naturally at 2^LW. This is how `len = 0` gives 256 samples.
- In DONE, `out_data = acc` and `out_idx = idx`. Both hold stable until the handshake.
- `start` in RUN or DONE is ignored. `op` and `len` changes after `start` are ignored.
- `in_valid` without `start` in IDLE is ignored, and no sample is consumed.

## Timing
- Reset values (async assert, sync deassert expected upstream):
  - state = IDLE, `in_ready` = 0, `out_valid` = 0, `busy` = 0.
  - `out_data` = 0, `out_idx` = 0, `acc` = 0, `cnt` = 0.
- `start` sampled in cycle t gives `in_ready` = 1 from t+1.
- Last sample accepted in cycle t gives `out_valid` = 1 in t+1, with `in_ready` = 0 in t+1. Latency is 1 cycle.
- Maximum throughput is one sample per cycle. A block of N samples with no stalls takes N+2 cycles from `start` to the first possible result handshake.
- Output handshake in cycle t: IDLE in t+1. A new `start` is accepted in t+1 at the earliest, not in t.
- `out_valid` holds until `out_ready` is asserted. A stalled output blocks new blocks indefinitely.
- `rst_n` low mid-block aborts immediately to reset values. A partial result is never emitted.

## Structure
- Shared package `au_pkg`:
  - op encodings `AU_OP_ABSMAX`, `AU_OP_MAX`, `AU_OP_MIN`.
  - state encoding (IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10).
  - `AU_W` = 16.
  - `AU_SAT_POS` = 16'h7FFF.
- One sub-module, `au_cmp_sel`: combinational transform (abs/saturate), signed compare, and the "better" flag for the given op. The top holds the FSM, counter and registers.

## Test plan
- Reset mid-RUN: assert `rst_n` = 0 after 3 of 8 samples, then restart with `len` = 2, samples {1, 2}, `op` 01. Required: all outputs return to reset values immediately, and the restarted block yields `out_data` = 2, `out_idx` = 1.
- op 01, `len` = 4, samples {5, -3, 9, 9}, `out_ready` = 1. Required: `out_data` = 9, `out_idx` = 2, `out_valid` exactly 1 cycle after the 4th accept.
- op 10, `len` = 3, samples {-7, 0x8000, 4}, with `in_valid` toggled every other cycle. Required: `out_data` = 0x8000, `out_idx` = 1. Stall cycles are not counted.
- op 00, `len` = 3, samples {-32768, 32767, -5}. Required: `out_data` = 0x7FFF, `out_idx` = 0 (saturation plus tie-keeps-first).
- `len` = 0, op 01, 256 samples ramping 0..255. Required: `out_data` = 255, `out_idx` = 255, 256 accepts then `in_ready` = 0.
- Output stall: hold `out_ready` = 0 for 5 cycles and pulse `start` during DONE. Required: `out_data`/`out_idx` stay stable, `start` is ignored, and IDLE follows the cycle after `out_ready` rises.

Source files
------------

// File: rtl/au_pkg.sv
// Shared definitions for the 16-bit arithmetic-unit stages: op codes,
// the reduce FSM state encoding and width constants.
package au_pkg;

    localparam int          AU_W       = 16;
    localparam logic [15:0] AU_SAT_POS = 16'h7FFF;

    // op[1] set selects min; 2'b11 aliases AU_OP_MIN
    localparam logic [1:0] AU_OP_ABSMAX = 2'b00;
    localparam logic [1:0] AU_OP_MAX    = 2'b01;
    localparam logic [1:0] AU_OP_MIN    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } au_state_e;

endpackage

// File: rtl/au_cmp_sel.sv
// Combinational sample transform (saturating abs for ABSMAX) and the
// "strictly better than accumulator" decision for the selected op.
module au_cmp_sel
    import au_pkg::*;
#(
    parameter int W = AU_W
) (
    input  logic [1:0]   op,
    input  logic [W-1:0] x,
    input  logic [W-1:0] acc,
    output logic [W-1:0] v,
    output logic         better
);

    localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG_MIN = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] abs_x;

    // Saturating |x| keeps the result positive, so a plain W-bit signed
    // compare is enough downstream.
    always_comb begin
        abs_x = x;
        if (x == NEG_MIN)
            abs_x = SAT_POS;
        else if (x[W-1])
            abs_x = W'(-x);
    end

    assign v = (op == AU_OP_ABSMAX) ? abs_x : x;

    always_comb begin
        if (op[1])
            better = $signed(v) < $signed(acc);
        else
            better = $signed(v) > $signed(acc);
    end

endmodule

// File: rtl/au_reduce16.sv
// Streaming block reducer: folds len samples through abs-max / max / min
// and returns the winning value plus its index via a valid/ready handshake.
module au_reduce16
    import au_pkg::*;
#(
    parameter int W  = AU_W,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [LW-1:0] len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [LW-1:0] out_idx,
    output logic          busy
);

    au_state_e     state;
    logic [1:0]    op_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] cnt;
    logic [W-1:0]  acc;
    logic [LW-1:0] idx;
    logic [W-1:0]  v;
    logic          better;
    logic          accept;

    au_cmp_sel #(.W(W)) u_cmp (
        .op     (op_q),
        .x      (in_data),
        .acc    (acc),
        .v      (v),
        .better (better)
    );

    assign in_ready  = (state == ST_RUN);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_data  = acc;
    assign out_idx   = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_q  <= '0;
            len_q <= '0;
            cnt   <= '0;
            acc   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        len_q <= len;
                        cnt   <= '0;
                        acc   <= '0;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (cnt == '0 || better) begin
                            acc <= v;
                            idx <= cnt;
                        end
                        // cnt wraps at 2^LW, so len==0 naturally means 2^LW samples
                        cnt <= cnt + 1'b1;
                        if (cnt == LW'(len_q - 1'b1))
                            state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_au_reduce16.sv
// Randomized and directed bench for au_reduce16 against a plain-arithmetic
// reference of the block reduction.
module tb_au_reduce16;

    localparam int W  = 16;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [LW-1:0] len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [LW-1:0] out_idx;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int smp[$];

    au_reduce16 #(.W(W), .LW(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int xform(input logic [1:0] o, input int x);
        int r;
        r = x;
        if (o == 2'b00) begin
            if (r < 0) r = -r;
            if (r > 32767) r = 32767;
        end
        return r;
    endfunction

    // Reference: scan the block, keep the first strictly-best transformed value.
    task automatic model(input logic [1:0] o, output int bv, output int bi);
        bv = 0;
        bi = 0;
        for (int i = 0; i < smp.size(); i++) begin
            int t;
            t = xform(o, smp[i]);
            if (i == 0 || (o[1] ? (t < bv) : (t > bv))) begin
                bv = t;
                bi = i;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_out_idx"}, 32'(out_idx), 32'd0);
    endtask

    // gap: 0..99 random idle percentage, 100 = exactly one idle cycle before each sample
    task automatic run_block(input string tag, input logic [1:0] o, input int gap,
                             input int ostall, input bit poke_start);
        int n, bv, bi;
        logic [W-1:0]  hold_d;
        logic [LW-1:0] hold_i;
        n = smp.size();
        model(o, bv, bi);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        len   = LW'(n);
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        len   = LW'($urandom);
        chk({tag, "_start_ready"}, 32'(in_ready), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (gap == 100) begin
                in_valid = 1'b0;
                @(negedge clk);
            end else begin
                while ($urandom_range(99) < gap) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = W'(smp[i]);
            if (!in_ready || out_valid) begin
                chk({tag, "_run_ready"}, 32'(in_ready), 32'd1);
                chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_done_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_data"}, 32'($signed(out_data)), 32'(bv));
        chk({tag, "_idx"}, 32'(out_idx), 32'(bi));
        hold_d = out_data;
        hold_i = out_idx;
        for (int k = 0; k < ostall; k++) begin
            start = poke_start;
            @(negedge clk);
            start = 1'b0;
            chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_stall_data"}, 32'(out_data), 32'(hold_d));
            chk({tag, "_stall_idx"}, 32'(out_idx), 32'(hold_i));
        end
        out_ready = 1'b1;
        start     = poke_start;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        #2;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("post_rst");

        // stray in_valid while idle must not start anything
        in_valid = 1'b1;
        in_data  = 16'h1234;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk("idle_valid_busy", 32'(busy), 32'd0);

        // abort mid-block, then restart
        start = 1'b1;
        op    = 2'b01;
        len   = 8'd8;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(100 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        @(negedge clk);
        rst_n = 1'b1;
        smp = '{1, 2};
        run_block("restart", 2'b01, 0, 0, 1'b0);

        smp = '{5, -3, 9, 9};
        run_block("max4", 2'b01, 0, 0, 1'b0);

        smp = '{-7, -32768, 4};
        run_block("min_gap", 2'b10, 100, 0, 1'b0);

        smp = '{-32768, 32767, -5};
        run_block("absmax_sat", 2'b00, 0, 0, 1'b0);

        smp = {};
        for (int i = 0; i < 256; i++) smp.push_back(i);
        run_block("len256", 2'b01, 0, 0, 1'b0);

        smp = '{3, -1, 8};
        run_block("ostall", 2'b11, 0, 5, 1'b1);

        for (int b = 0; b < 25; b++) begin
            int n;
            n = $urandom_range(1, 12);
            smp = {};
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(5))
                    0: smp.push_back(-32768);
                    1: smp.push_back(32767);
                    2: smp.push_back($urandom_range(8) - 4);
                    default: smp.push_back(int'($signed(16'($urandom))));
                endcase
            end
            run_block("rand", 2'($urandom), 30, $urandom_range(3), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
